// File: rtl/aqed_dup_sequencer.sv
// A-QED duplicate-check sequencer: gates host writes into a memory core, marks the
// original/duplicate writes with exec_dup, drains the core and latches a verdict.
module aqed_dup_sequencer #(
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              start,
    input  logic [IDX_W-1:0]  orig_idx,
    input  logic [IDX_W-1:0]  gap_len,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ready,
    input  logic              full,
    input  logic              empty,
    input  logic              valid_out,
    output logic              wen,
    output logic              ren,
    output logic [DATA_W-1:0] wdata,
    output logic              exec_dup,
    input  logic              qed_done,
    input  logic              qed_check,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_ORIG, S_GAP, S_DUP, S_DRAIN, S_DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] orig_r;
    logic [IDX_W-1:0] gap_r;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] cnt_nx;
    logic [TW-1:0]    tcnt;
    logic             pass_r;
    logic             timeout_r;
    logic             in_write;
    logic             in_run;
    logic             acc;
    logic             abort;

    // valid_out is part of the core status bundle but does not steer sequencing
    logic unused_ok;
    assign unused_ok = valid_out;

    always_comb begin
        in_write   = (state == S_PRE) || (state == S_ORIG) || (state == S_GAP) || (state == S_DUP);
        in_run     = in_write || (state == S_DRAIN);
        abort      = reset || flush;
        wen        = host_valid & in_write & ~abort;
        ren        = ~empty & in_run & ~abort;
        exec_dup   = ((state == S_ORIG) || (state == S_DUP)) & ~abort;
        acc        = wen & clk_en & ~flush & (~full | ren);
        host_ready = acc;
        wdata      = host_data;
        busy       = in_run;
        done       = (state == S_DONE);
        pass       = pass_r;
        timeout    = timeout_r;
        cnt_nx     = cnt + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || (clk_en && flush)) begin
            state     <= S_IDLE;
            orig_r    <= '0;
            gap_r     <= '0;
            cnt       <= '0;
            tcnt      <= '0;
            pass_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else if (clk_en) begin
            case (state)
                // DONE accepts start directly so a new run begins without an idle cycle
                S_IDLE, S_DONE: begin
                    if (start) begin
                        orig_r    <= orig_idx;
                        gap_r     <= gap_len;
                        cnt       <= '0;
                        tcnt      <= '0;
                        pass_r    <= 1'b0;
                        timeout_r <= 1'b0;
                        state     <= (orig_idx == '0) ? S_ORIG : S_PRE;
                    end
                end
                S_PRE: begin
                    if (acc) begin
                        if (cnt_nx == orig_r) begin
                            cnt   <= '0;
                            state <= S_ORIG;
                        end else begin
                            cnt <= cnt_nx;
                        end
                    end
                end
                S_ORIG: begin
                    if (acc) begin
                        cnt   <= '0;
                        state <= (gap_r == '0) ? S_DUP : S_GAP;
                    end
                end
                S_GAP: begin
                    if (acc) begin
                        if (cnt_nx == gap_r) begin
                            cnt   <= '0;
                            state <= S_DUP;
                        end else begin
                            cnt <= cnt_nx;
                        end
                    end
                end
                S_DUP: begin
                    if (acc) begin
                        tcnt  <= '0;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (empty && qed_done) begin
                        pass_r <= qed_check;
                        state  <= S_DONE;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        timeout_r <= 1'b1;
                        pass_r    <= 1'b0;
                        state     <= S_DONE;
                    end else if (tcnt != '1) begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
